// File: rtl/pipeline_debug_controller.sv
// Run/step/breakpoint controller for the pipeline clock enable, plus a frozen
// snapshot streamer that feeds the UART transmitter one byte at a time.
module pipeline_debug_controller #(
  parameter int PC_WIDTH  = 11,
  parameter int NUM_BP    = 4,
  parameter int NUM_WORDS = 48,
  parameter int BP_IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [15:0]              cmd_arg,
  input  logic [BP_IDX_W-1:0]      cmd_idx,
  input  logic [PC_WIDTH-1:0]      current_pc,
  input  logic [NUM_WORDS*32-1:0]  snap_data,
  output logic                     pipe_enable,
  output logic                     halted,
  output logic [31:0]              cycle_count,
  output logic [7:0]               tx_byte,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [1:0]               dbg_state
);

  localparam int DUMP_BYTES = 1 + 4 * NUM_WORDS + 4;
  localparam int BYTE_IDX_W = $clog2(DUMP_BYTES);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(DUMP_BYTES - 1);

  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd2;
  localparam logic [2:0] OP_HALT   = 3'd3;
  localparam logic [2:0] OP_SET_BP = 3'd4;
  localparam logic [2:0] OP_CLR_BP = 3'd5;
  localparam logic [2:0] OP_DUMP   = 3'd6;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DUMP = 2'd3
  } state_t;

  state_t                  state, state_next;
  logic                    skip, skip_next;
  logic [15:0]             step_cnt, step_cnt_next;
  logic [BYTE_IDX_W-1:0]   byte_idx, byte_idx_next;
  logic [PC_WIDTH-1:0]     bp_pc [NUM_BP];
  logic [NUM_BP-1:0]       bp_en;
  logic [7:0]              shadow [DUMP_BYTES];
  logic                    accept, bp_hit, bp_stop;
  logic                    dump_start, bp_set, bp_clr;

  // Handshakes: a command transfers on a cycle with cmd_valid & cmd_ready, a
  // byte on a cycle with tx_valid & tx_ready; an offered byte never changes
  // while it waits for tx_ready.
  assign cmd_ready   = (state != ST_DUMP);
  assign accept      = cmd_valid & cmd_ready;
  assign halted      = (state == ST_HALT);
  assign tx_valid    = (state == ST_DUMP);
  assign tx_byte     = tx_valid ? shadow[byte_idx] : 8'h00;
  assign dbg_state   = state;
  assign bp_stop     = bp_hit & ~skip;
  assign pipe_enable = ((state == ST_RUN) & ~bp_stop) | (state == ST_STEP);

  always_comb begin
    bp_hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && (bp_pc[i] == current_pc)) bp_hit = 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    skip_next     = 1'b0;
    step_cnt_next = step_cnt;
    byte_idx_next = byte_idx;
    dump_start    = 1'b0;
    bp_set        = 1'b0;
    bp_clr        = 1'b0;
    case (state)
      ST_RUN: begin
        if (bp_stop) state_next = ST_HALT;
      end
      ST_STEP: begin
        if (step_cnt <= 16'd1) begin
          state_next    = ST_HALT;
          step_cnt_next = '0;
        end else begin
          step_cnt_next = step_cnt - 16'd1;
        end
      end
      ST_DUMP: begin
        if (tx_ready) begin
          if (byte_idx == LAST_BYTE) begin
            state_next    = ST_HALT;
            byte_idx_next = '0;
          end else begin
            byte_idx_next = byte_idx + BYTE_IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
    // Accepted commands override the state's own progress (STEP beats a hit).
    if (accept) begin
      case (cmd_op)
        OP_RUN: begin
          if (state != ST_RUN) begin
            state_next = ST_RUN;
            skip_next  = 1'b1;
          end
        end
        OP_STEP: begin
          state_next    = ST_STEP;
          step_cnt_next = (cmd_arg == 16'd0) ? 16'd1 : cmd_arg;
        end
        OP_HALT:   state_next = ST_HALT;
        OP_SET_BP: bp_set = 1'b1;
        OP_CLR_BP: bp_clr = 1'b1;
        OP_DUMP: begin
          if (state == ST_HALT) begin
            state_next    = ST_DUMP;
            dump_start    = 1'b1;
            byte_idx_next = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_HALT;
      skip        <= 1'b0;
      step_cnt    <= '0;
      byte_idx    <= '0;
      cycle_count <= '0;
      bp_en       <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_pc[i] <= '0;
    end else begin
      state    <= state_next;
      skip     <= skip_next;
      step_cnt <= step_cnt_next;
      byte_idx <= byte_idx_next;
      if (pipe_enable) cycle_count <= cycle_count + 32'd1;
      if (bp_clr) begin
        bp_en <= '0;
      end else if (bp_set) begin
        for (int i = 0; i < NUM_BP; i++) begin
          if (cmd_idx == BP_IDX_W'(i)) begin
            bp_pc[i] <= cmd_arg[PC_WIDTH-1:0];
            bp_en[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Snapshot image in transmit order: header, words little-endian, then count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DUMP_BYTES; i++) shadow[i] <= '0;
    end else if (dump_start) begin
      shadow[0] <= 8'hA5;
      for (int k = 0; k < NUM_WORDS; k++) begin
        for (int b = 0; b < 4; b++) begin
          shadow[1 + 4 * k + b] <= snap_data[32 * k + 8 * b +: 8];
        end
      end
      for (int b = 0; b < 4; b++) begin
        shadow[1 + 4 * NUM_WORDS + b] <= cycle_count[8 * b +: 8];
      end
    end
  end

endmodule

// File: doc/pipeline_debug_controller.md
# pipeline_debug_controller

Parametrised run/step/breakpoint controller for the MIPS pipeline, the next generation of the debug path that currently just gates `pipeline_clock` from the UART unit. It sits between the UART command decoder and the five pipeline stages. It produces a single clock-enable for the stages and supports free-run, N-cycle step and PC breakpoints. It also streams a frozen snapshot of the stage debug words as a byte stream to the UART transmitter.

## Interface

**Parameters**
- `PC_WIDTH`, 11 — width of the fetch PC compared against breakpoints.
- `NUM_BP`, 4 — number of PC breakpoint slots (1..16).
- `NUM_WORDS`, 48 — number of 32-bit debug words in the snapshot.
- `BP_IDX_W`, $clog2(NUM_BP) with minimum 1 — width of the breakpoint index.

**Ports**
- `clock` in 1 — single system clock; all logic is on its rising edge.
- `reset` in 1 — asynchronous, active-low.
- `cmd_valid` in 1 — a command is presented.
- `cmd_ready` out 1 — the command is accepted on a cycle where `cmd_valid & cmd_ready`.
- `cmd_op` in 3 — opcode: 0 NOP, 1 RUN, 2 STEP, 3 HALT, 4 SET_BP, 5 CLR_BP, 6 DUMP, 7 NOP.
- `cmd_arg` in 16 — STEP count, or the breakpoint PC in `[PC_WIDTH-1:0]`.
- `cmd_idx` in BP_IDX_W — breakpoint slot for SET_BP.
- `current_pc` in PC_WIDTH — PC currently in IF.
- `snap_data` in NUM_WORDS*32 — concatenated debug words; word k is `[32k+31:32k]`.
- `pipe_enable` out 1 — clock enable for all pipeline stage registers.
- `halted` out 1 — high in the HALT state.
- `cycle_count` out 32 — number of cycles on which `pipe_enable` was high.
- `tx_byte` out 8 — snapshot byte.
- `tx_valid` out 1, `tx_ready` in 1 — byte handshake with the UART TX FIFO.

## Operation

- **States:** HALT, RUN, STEP, DUMP.
- **Reset values:**
  - state HALT, so `halted`=1 and `pipe_enable`=0.
  - `cmd_ready`=1, `cycle_count`=0.
  - `tx_valid`=0, `tx_byte`=0x00.
  - all breakpoint slots disabled; step counter 0; skip flag 0.
- **`pipe_enable`** = (state==RUN & ~(bp_hit & ~skip)) | state==STEP. It is combinational from registered state, `current_pc` and the breakpoint registers.
  - `bp_hit` is high when any enabled slot equals `current_pc`.
- **`cmd_ready`** = (state != DUMP).
- **RUN**
  - Accepted in any non-DUMP state. Sets skip=1 for the first RUN cycle only, so resuming from a breakpoint PC does not re-trigger.
  - While in RUN, an unskipped bp_hit moves the state to HALT. `pipe_enable` is already low on the hit cycle, so the pipeline freezes with IF holding the breakpoint PC.
  - RUN while already in RUN: no change, skip not re-armed.
- **STEP**
  - Loads the step counter with `cmd_arg`; an argument of 0 is treated as 1.
  - The state is STEP for exactly that many cycles, with `pipe_enable`=1 on each, then returns to HALT.
  - Breakpoints are ignored in STEP.
  - STEP received in RUN or STEP reloads the counter and enters STEP.
- **HALT:** state becomes HALT; it is a no-op if already halted.
- **SET_BP:** writes `cmd_arg[PC_WIDTH-1:0]` into slot `cmd_idx` and enables the slot. If `cmd_idx` ≥ NUM_BP the command is accepted and ignored.
- **CLR_BP:** disables all slots.
- **DUMP**
  - Accepted only in HALT; in any other state it is accepted and ignored.
  - On acceptance, the block latches `snap_data` and `cycle_count` into a shadow register, then sends 1+4·NUM_WORDS+4 bytes:
    - header 0xA5;
    - words 0..NUM_WORDS-1, each little-endian;
    - `cycle_count`, little-endian.
  - After the final byte handshake the state returns to HALT.
- **Simultaneous events:**
  - A HALT command and an unskipped bp_hit on the same cycle give HALT (same outcome either way).
  - A STEP command on a bp_hit cycle wins: the next state is STEP.
- **Counter widths:** `cycle_count` increments on every cycle with `pipe_enable`=1 and wraps 0xFFFFFFFF→0. The step counter is 16 bits.

## Timing

- A command accepted at edge T becomes the new state visible after T. `pipe_enable` reflects the new state in cycle T+1.
- STEP n: `pipe_enable` is high in cycles T+1..T+n and `halted`=1 from T+n+1.
- **DUMP byte stream:**
  - `tx_valid` rises in cycle T+1 with `tx_byte`=0xA5.
  - Each byte is held stable while `tx_valid & ~tx_ready`.
  - After a handshake, the next byte is presented the following cycle; there are no gaps when `tx_ready` stays high.
  - `tx_valid` falls the cycle after the last handshake, and `cmd_ready` rises in that same cycle.
- **Reset mid-operation:** an asynchronous assertion forces all reset values immediately. This includes aborting a DUMP with `tx_valid`=0 and clearing breakpoints.
- Stage inputs are not sampled on the snapshot path after latch, so snapshot bytes are immune to `snap_data` changes during DUMP.

## Test plan

- **Reset then STEP arg=3:** `pipe_enable` high exactly 3 cycles; `cycle_count`=3; `halted`=1 afterwards. STEP arg=0 gives exactly 1 cycle.
- **SET_BP idx0 PC=0x010, then RUN from PC 0:** halts with `current_pc`=0x010 and `pipe_enable` low on the match cycle. A second RUN advances past 0x010 without re-halting.
- **SET_BP idx=NUM_BP (NUM_BP=3 build):** ignored, no halt. CLR_BP during RUN: the next match is not taken.
- **DUMP with NUM_WORDS=2, words 0x11223344, 0xAABBCCDD, cycle_count 5, `tx_ready` toggling 1/0:** bytes A5 44 33 22 11 DD CC BB AA 05 00 00 00. Every byte is stable while stalled, and `cmd_ready`=0 throughout.
- **DUMP issued in RUN:** ignored, no `tx_valid`. `reset` pulled low mid-DUMP: `tx_valid`=0 and `halted`=1 immediately.
- **Preload `cycle_count` to 0xFFFFFFFE, then STEP 3:** wraps to 0x00000001.
